// File: rtl/huffman_seq_ctrl.sv
// Top-level sequencer for the Huffman encoder: runs count, sort, tree build and
// code generation in order, with a per-stage watchdog, abort and job timing.
module huffman_seq_ctrl #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TW      = 13,
  parameter int unsigned JW      = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          abort,
  output logic          cnt_en,
  input  logic          cnt_over,
  output logic          sort_en,
  input  logic          sort_over,
  output logic          tree_en,
  input  logic          tree_over_in,
  output logic          code_en,
  input  logic          code_over,
  output logic          table_latch,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    err_stage,
  output logic [JW-1:0] job_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    S_CNT,
    S_SORT,
    S_TREE,
    S_CODE,
    S_DONE,
    ERR
  } state_e;

  state_e        state_q, state_d;
  state_e        adv_state;
  logic [TW-1:0] wd_q, wd_d;
  logic [JW-1:0] jc_q, jc_d;

  logic          cnt_en_q, cnt_en_d;
  logic          sort_en_q, sort_en_d;
  logic          tree_en_q, tree_en_d;
  logic          code_en_q, code_en_d;
  logic          table_latch_q, table_latch_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [2:0]    err_stage_q, err_stage_d;
  logic [JW-1:0] job_cycles_q, job_cycles_d;

  logic          in_stage;
  logic          stage_over;
  logic [2:0]    stage_code;
  logic          first_cycle;
  logic          wd_expired;

  // Per-stage view of the current state: its over flag, error code and successor.
  always_comb begin : stage_decode
    in_stage   = 1'b0;
    stage_over = 1'b0;
    stage_code = 3'd0;
    adv_state  = IDLE;
    case (state_q)
      S_CNT: begin
        in_stage   = 1'b1;
        stage_over = cnt_over;
        stage_code = 3'd1;
        adv_state  = S_SORT;
      end
      S_SORT: begin
        in_stage   = 1'b1;
        stage_over = sort_over;
        stage_code = 3'd2;
        adv_state  = S_TREE;
      end
      S_TREE: begin
        in_stage   = 1'b1;
        stage_over = tree_over_in;
        stage_code = 3'd3;
        adv_state  = S_CODE;
      end
      S_CODE: begin
        in_stage   = 1'b1;
        stage_over = code_over;
        stage_code = 3'd4;
        adv_state  = S_DONE;
      end
      default: ;
    endcase
  end

  // The watchdog is zero only on the first cycle of a stage, so it doubles as
  // the stale-over mask.
  assign first_cycle = (wd_q == '0);
  assign wd_expired  = (wd_q == TW'(TIMEOUT - 1));

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = S_CNT;
      end
      S_CNT, S_SORT, S_TREE, S_CODE: begin
        if (abort)                          state_d = IDLE;
        else if (!first_cycle && stage_over) state_d = adv_state;
        else if (wd_expired)                state_d = ERR;
      end
      S_DONE:  state_d = IDLE;
      ERR: begin
        if (start) state_d = S_CNT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : counters
    wd_d = '0;
    if (in_stage && (state_d == state_q)) wd_d = wd_q + TW'(1);

    jc_d = jc_q;
    if (in_stage)                jc_d = (jc_q == '1) ? jc_q : jc_q + JW'(1);
    else if (state_d == S_CNT)   jc_d = '0;
  end

  // Outputs are decoded from the next state so they are registered yet aligned
  // with the state they describe.
  always_comb begin : output_decode
    cnt_en_d      = (state_d == S_CNT);
    sort_en_d     = (state_d == S_SORT);
    tree_en_d     = (state_d == S_TREE);
    code_en_d     = (state_d == S_CODE);
    busy_d        = cnt_en_d | sort_en_d | tree_en_d | code_en_d;
    done_d        = (state_d == S_DONE);
    table_latch_d = (state_d == S_DONE);
    err_d         = (state_d == ERR);
    err_stage_d   = '0;
    if (state_d == ERR) err_stage_d = (state_q == ERR) ? err_stage_q : stage_code;
    job_cycles_d  = (state_d == S_DONE) ? jc_d : job_cycles_q;
  end

  always_ff @(posedge CLK) begin : regs
    if (RST) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      jc_q          <= '0;
      cnt_en_q      <= 1'b0;
      sort_en_q     <= 1'b0;
      tree_en_q     <= 1'b0;
      code_en_q     <= 1'b0;
      table_latch_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_stage_q   <= '0;
      job_cycles_q  <= '0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      jc_q          <= jc_d;
      cnt_en_q      <= cnt_en_d;
      sort_en_q     <= sort_en_d;
      tree_en_q     <= tree_en_d;
      code_en_q     <= code_en_d;
      table_latch_q <= table_latch_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_stage_q   <= err_stage_d;
      job_cycles_q  <= job_cycles_d;
    end
  end

  assign cnt_en      = cnt_en_q;
  assign sort_en     = sort_en_q;
  assign tree_en     = tree_en_q;
  assign code_en     = code_en_q;
  assign table_latch = table_latch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_stage   = err_stage_q;
  assign job_cycles  = job_cycles_q;

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
// Bench for huffman_seq_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a step-level behavioural model.
module tb_huffman_seq_ctrl;

  localparam int TO   = 8;
  localparam int JW   = 5;
  localparam int JMAX = (1 << JW) - 1;

  logic          CLK = 1'b0;
  logic          RST, start, abort;
  logic          cnt_over, sort_over, tree_over_in, code_over;
  logic          cnt_en, sort_en, tree_en, code_en;
  logic          table_latch, busy, done, err;
  logic [2:0]    err_stage;
  logic [JW-1:0] job_cycles;

  always #5 CLK = ~CLK;

  huffman_seq_ctrl #(.TIMEOUT(TO), .TW(4), .JW(JW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .cnt_en(cnt_en), .cnt_over(cnt_over),
    .sort_en(sort_en), .sort_over(sort_over),
    .tree_en(tree_en), .tree_over_in(tree_over_in),
    .code_en(code_en), .code_over(code_over),
    .table_latch(table_latch), .busy(busy), .done(done), .err(err),
    .err_stage(err_stage), .job_cycles(job_cycles)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1..4 = stages in order, 5 = done, 6 = error.
  // age counts cycles already spent in the current stage.
  int m_st = 0, m_age = 0, m_jc = 0, m_job = 0, m_errst = 0;

  always @(posedge CLK) begin : model
    int st, age, jc, job, es;
    bit [4:1] ov;
    st = m_st; age = m_age; jc = m_jc; job = m_job; es = m_errst;
    ov = {code_over, tree_over_in, sort_over, cnt_over};
    if (RST) begin
      st = 0; age = 0; jc = 0; job = 0; es = 0;
    end else if (st == 0) begin
      if (start && !abort) begin st = 1; age = 0; jc = 0; end
    end else if (st >= 1 && st <= 4) begin
      jc = (jc < JMAX) ? jc + 1 : JMAX;
      if (abort) st = 0;
      else if (age > 0 && ov[st]) begin
        st = st + 1;
        age = 0;
        if (st == 5) job = jc;
      end else if (age == TO - 1) begin
        es = st;
        st = 6;
      end else age = age + 1;
    end else if (st == 5) begin
      st = 0;
    end else if (start) begin
      st = 1; age = 0; jc = 0; es = 0;
    end
    m_st <= st; m_age <= age; m_jc <= jc; m_job <= job; m_errst <= es;
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("cnt_en",      int'(cnt_en),      int'(m_st == 1));
      chk("sort_en",     int'(sort_en),     int'(m_st == 2));
      chk("tree_en",     int'(tree_en),     int'(m_st == 3));
      chk("code_en",     int'(code_en),     int'(m_st == 4));
      chk("busy",        int'(busy),        int'(m_st >= 1 && m_st <= 4));
      chk("done",        int'(done),        int'(m_st == 5));
      chk("table_latch", int'(table_latch), int'(m_st == 5));
      chk("err",         int'(err),         int'(m_st == 6));
      chk("err_stage",   int'(err_stage),   (m_st == 6) ? m_errst : 0);
      chk("job_cycles",  int'(job_cycles),  m_job);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_overs(input logic [3:0] v);
    {code_over, tree_over_in, sort_over, cnt_over} = v;
  endtask

  task automatic begin_job();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [3:0] en_h [0:99];
  logic       dn_h [0:99];
  logic       tl_h [0:99];
  logic       bs_h [0:99];
  int         done_cyc, jc_done;

  // Each stage's over is raised on the d-th cycle its enable is high.
  task automatic run_job(input int d);
    int age;
    logic [3:0] prev, cur;
    for (int i = 0; i < 100; i++) begin
      en_h[i] = '0; dn_h[i] = 1'b0; tl_h[i] = 1'b0; bs_h[i] = 1'b0;
    end
    done_cyc = -1; jc_done = -1; age = 0; prev = '0;
    begin_job();
    for (int c = 1; c <= 90; c++) begin
      cur = {code_en, tree_en, sort_en, cnt_en};
      en_h[c] = cur; dn_h[c] = done; tl_h[c] = table_latch; bs_h[c] = busy;
      if (done && done_cyc < 0) begin
        done_cyc = c;
        jc_done  = int'(job_cycles);
      end
      if (done_cyc >= 0 && c > done_cyc) break;
      age  = (cur != '0 && cur == prev) ? age + 1 : ((cur != '0) ? 1 : 0);
      prev = cur;
      set_overs((age == d) ? cur : 4'b0);
      tick();
    end
    set_overs(4'b0);
    chk("job_done_within_bound", int'(done_cyc >= 0), 1);
  endtask

  task automatic check_nominal(input string tag);
    for (int c = 1; c <= 26; c++) begin
      chk({tag, "_cnt_en"},  int'(en_h[c][0]), int'(c >= 1  && c <= 6));
      chk({tag, "_sort_en"}, int'(en_h[c][1]), int'(c >= 7  && c <= 12));
      chk({tag, "_tree_en"}, int'(en_h[c][2]), int'(c >= 13 && c <= 18));
      chk({tag, "_code_en"}, int'(en_h[c][3]), int'(c >= 19 && c <= 24));
      chk({tag, "_done"},    int'(dn_h[c]),    int'(c == 25));
      chk({tag, "_latch"},   int'(tl_h[c]),    int'(c == 25));
      chk({tag, "_busy"},    int'(bs_h[c]),    int'(c <= 24));
    end
    chk({tag, "_done_cycle"}, done_cyc, 25);
    chk({tag, "_job_cycles"}, jc_done, 24);
  endtask

  initial begin
    int cnt_n, first_err, es_at_err, en_at_err, pulses;
    RST = 1'b1; start = 1'b0; abort = 1'b0; set_overs(4'b0);
    tick();
    chk_on = 1'b1;
    tick();
    chk("reset_busy",       int'(busy),       0);
    chk("reset_enables",    int'({cnt_en, sort_en, tree_en, code_en}), 0);
    chk("reset_done_latch", int'({done, table_latch}), 0);
    chk("reset_err",        int'(err),        0);
    chk("reset_err_stage",  int'(err_stage),  0);
    chk("reset_job_cycles", int'(job_cycles), 0);
    RST = 1'b0;
    tick();

    // Nominal job.
    run_job(6);
    check_nominal("nom");

    // Stale sort_over held before S_SORT is entered.
    cnt_n = 0;
    set_overs(4'b0111);
    begin_job();
    for (int c = 1; c <= 12; c++) begin
      cnt_n += int'(sort_en);
      abort = code_en;
      tick();
    end
    abort = 1'b0; set_overs(4'b0);
    chk("stale_sort_cycles", cnt_n, 2);

    // Tree stage watchdog timeout.
    cnt_n = 0; first_err = -1; es_at_err = -1; en_at_err = -1;
    set_overs(4'b0011);
    begin_job();
    for (int c = 1; c <= 20; c++) begin
      cnt_n += int'(tree_en);
      if (err && first_err < 0) begin
        first_err = c;
        es_at_err = int'(err_stage);
        en_at_err = int'({cnt_en, sort_en, tree_en, code_en});
      end
      abort = (c == 15);
      tick();
    end
    abort = 1'b0; set_overs(4'b0);
    chk("timeout_tree_cycles", cnt_n, 8);
    chk("timeout_err_cycle",   first_err, 13);
    chk("timeout_err_stage",   es_at_err, 3);
    chk("timeout_enables",     en_at_err, 0);
    chk("err_held",            int'(err), 1);
    begin_job();
    chk("err_restart_cnt_en",  int'(cnt_en), 1);
    chk("err_restart_err",     int'(err), 0);
    chk("err_restart_stage",   int'(err_stage), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cnt_idle", int'(busy), 0);

    // Abort coinciding with code_over.
    pulses = 0;
    set_overs(4'b1111);
    begin_job();
    for (int c = 1; c <= 14; c++) begin
      pulses += int'(done) + int'(table_latch);
      if (c == 8) chk("abort_in_code", int'(code_en), 1);
      if (c == 9) begin
        chk("abort_busy",    int'(busy), 0);
        chk("abort_code_en", int'(code_en), 0);
      end
      abort = (c == 8);
      tick();
    end
    abort = 1'b0; set_overs(4'b0);
    chk("abort_no_pulses",     pulses, 0);
    chk("abort_job_unchanged", int'(job_cycles), 24);

    // Start while busy, then start+abort together in IDLE.
    set_overs(4'b0001);
    begin_job();
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        chk("busy_start_sort", int'(sort_en), 1);
        chk("busy_start_cnt",  int'(cnt_en), 0);
      end
      if (c == 9 || c == 10) begin
        chk("idle_start_abort_busy", int'(busy), 0);
        chk("idle_start_abort_cnt",  int'(cnt_en), 0);
      end
      start = (c == 4) || (c == 8);
      abort = (c == 6) || (c == 8);
      tick();
    end
    start = 1'b0; abort = 1'b0; set_overs(4'b0);

    // Reset in the middle of the tree stage.
    set_overs(4'b1111);
    begin_job();
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) chk("rst_in_tree", int'(tree_en), 1);
      if (c == 6) begin
        chk("rst_enables",    int'({cnt_en, sort_en, tree_en, code_en}), 0);
        chk("rst_flags",      int'({busy, done, table_latch, err}), 0);
        chk("rst_err_stage",  int'(err_stage), 0);
        chk("rst_job_cycles", int'(job_cycles), 0);
      end
      RST = (c == 5);
      tick();
    end
    RST = 1'b0; set_overs(4'b0);
    run_job(6);
    check_nominal("post_rst");

    // Over on the watchdog's last cycle wins; 32-cycle job saturates a 5-bit count.
    run_job(8);
    chk("sat_done_cycle", done_cyc, 33);
    chk("sat_job_cycles", jc_done, 31);
    run_job(7);
    chk("len28_done_cycle", done_cyc, 29);
    chk("len28_job_cycles", jc_done, 28);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      RST          = ($urandom_range(0, 199) == 0);
      start        = ($urandom_range(0, 7) == 0);
      abort        = ($urandom_range(0, 39) == 0);
      cnt_over     = ($urandom_range(0, 3) == 0);
      sort_over    = ($urandom_range(0, 3) == 0);
      tree_over_in = ($urandom_range(0, 4) == 0);
      code_over    = ($urandom_range(0, 3) == 0);
      tick();
    end
    RST = 1'b0; start = 1'b0; abort = 1'b0; set_overs(4'b0);
    tick();
    tick();
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
